// File: rtl/ks10_bus_arbiter_pkg.sv
// ks10_bus_pkg: bus FSM state enum, default KS10 bus widths and the device-index width helper
package ks10_bus_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, NXM} busstate_t;
  localparam int NDEV_DEF = 4;
  localparam int AWIDTH_DEF = 36;
  localparam int DWIDTH_DEF = 36;
  localparam int NINTR_DEF = 7;
  localparam int TIMEOUT_DEF = 127;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ks10_bus_arbiter_if.sv
// ks10_bus_arbiter_if: KS10 backplane bundle; *O = device-driven, *I/GNT/ERR/NXM = arbiter-driven; master = arbiter, slave = device
interface ks10_bus_arbiter_if
  import ks10_bus_pkg::*;
#(
  parameter int NDEV = NDEV_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NINTR = NINTR_DEF
);
  logic [NDEV-1:0] busREQO, busACKO;
  logic [NDEV-1:0][AWIDTH-1:0] busADDRO;
  logic [NDEV-1:0][DWIDTH-1:0] busDATAO;
  logic [NDEV-1:0][NINTR-1:0] busINTRO;
  logic busREQI;
  logic [AWIDTH-1:0] busADDRI;
  logic [DWIDTH-1:0] busDATAI;
  logic [NDEV-1:0] busACKI, busNXM;
  logic [NINTR-1:0] busINTRI;
  logic [idx_w(NDEV)-1:0] busGNT;
  logic busERR;
  modport master (
    input busREQO, busACKO, busADDRO, busDATAO, busINTRO,
    output busREQI, busADDRI, busDATAI, busACKI, busNXM, busINTRI, busGNT, busERR
  );
  modport slave (
    output busREQO, busACKO, busADDRO, busDATAO, busINTRO,
    input busREQI, busADDRI, busDATAI, busACKI, busNXM, busINTRI, busGNT, busERR
  );
endinterface

// File: rtl/ks10_bus_arbiter_rr_arb.sv
// ks10_rr_arb: combinational round-robin pick; req_i/ptr_i in, vld_o/idx_o = first requester at or after ptr_i+1
module ks10_rr_arb
  import ks10_bus_pkg::*;
#(
  parameter int NDEV = NDEV_DEF,
  parameter int GW = idx_w(NDEV)
) (
  input  logic [NDEV-1:0] req_i,
  input  logic [GW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [GW-1:0]   idx_o
);
  logic [GW-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int i = NDEV; i >= 1; i--) begin
      j = GW'((int'(ptr_i) + i) % NDEV);
      if (req_i[j]) idx_o = j;
    end
  end
  assign vld_o = |req_i;
endmodule

// File: rtl/ks10_bus_arbiter.sv
// ks10_bus_arbiter: round-robin KS10 bus arbiter/crossbar with NXM timeout; ports clk, rst_n (sync active-low), bus (master modport)
module ks10_bus_arbiter
  import ks10_bus_pkg::*;
#(
  parameter int NDEV = NDEV_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NINTR = NINTR_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst_n,
  ks10_bus_arbiter_if.master bus
);
  localparam int GW = idx_w(NDEV);
  busstate_t state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, idx;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] dat_q, dat_d, ack_dat;
  logic [9:0] cnt_q, cnt_d;
  logic [NDEV-1:0] acki_q, acki_d, nxm_q, nxm_d, req_m, ack_m;
  logic [NINTR-1:0] intr_q, intr_d;
  logic reqi_q, reqi_d, err_q, err_d, vld;
  // a requester being answered this cycle is stale and must not be re-granted
  assign req_m = bus.busREQO & ~(acki_q | nxm_q);
  assign ack_m = bus.busACKO & ~(NDEV'(1) << gnt_q);
  ks10_rr_arb #(.NDEV(NDEV), .GW(GW)) u_arb (.req_i(req_m), .ptr_i(ptr_q), .vld_o(vld), .idx_o(idx));
  always_comb begin
    ack_dat = '0;
    intr_d = '0;
    for (int i = 0; i < NDEV; i++) begin
      ack_dat |= ack_m[i] ? bus.busDATAO[i] : '0;
      intr_d |= bus.busINTRO[i];
    end
  end
  // outputs are decoded from the next state so every bus output is a flop
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    dat_d = '0;
    case (state_q)
      IDLE: if (vld) begin
        gnt_d = idx;
        addr_d = bus.busADDRO[idx];
        dat_d = bus.busDATAO[idx];
        state_d = REQ;
      end
      REQ: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (ack_m != '0) begin
        dat_d = ack_dat;
        err_d = err_q || ((ack_m & (ack_m - NDEV'(1))) != '0);
        state_d = DONE;
      end else if (cnt_q == 10'(TIMEOUT - 1)) state_d = NXM;
      else cnt_d = cnt_q + 10'd1;
      DONE, NXM: begin
        ptr_d = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    reqi_d = state_d == REQ;
    acki_d = state_d == DONE ? NDEV'(1) << gnt_d : '0;
    nxm_d = state_d == NXM ? NDEV'(1) << gnt_d : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      addr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
      acki_q <= '0;
      nxm_q <= '0;
      intr_q <= '0;
      reqi_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      acki_q <= acki_d;
      nxm_q <= nxm_d;
      intr_q <= intr_d;
      reqi_q <= reqi_d;
      err_q <= err_d;
    end
  end
  assign bus.busREQI = reqi_q;
  assign bus.busADDRI = addr_q;
  assign bus.busDATAI = dat_q;
  assign bus.busACKI = acki_q;
  assign bus.busNXM = nxm_q;
  assign bus.busINTRI = intr_q;
  assign bus.busGNT = gnt_q;
  assign bus.busERR = err_q;
endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// tb_ks10_bus_arbiter: table-driven transactions plus interrupt, mid-transaction reset and round-robin sequences
module tb_ks10_bus_arbiter;
  localparam int ND = 4, AW = 36, DW = 36, NI = 7, TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ks10_bus_arbiter_if #(.NDEV(ND), .AWIDTH(AW), .DWIDTH(DW), .NINTR(NI)) bus ();
  ks10_bus_arbiter #(.NDEV(ND), .AWIDTH(AW), .DWIDTH(DW), .NINTR(NI), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {
    int dev;
    logic [ND-1:0] ack;
    int dly;
    logic [AW-1:0] addr;
    logic [ND-1:0][DW-1:0] dat;
    logic [ND-1:0] eack;
    logic [ND-1:0] enxm;
    logic [DW-1:0] edat;
    int ecyc;
    int egnt;
    logic eerr;
  } vec_t;
  vec_t v[5];
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [ND-1:0][DW-1:0] dat4(input logic [DW-1:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction
  task automatic chk_zero(input string n);
    chk({n, ".reqi"}, bus.busREQI, 0);
    chk({n, ".addri"}, bus.busADDRI, 0);
    chk({n, ".datai"}, bus.busDATAI, 0);
    chk({n, ".acki"}, bus.busACKI, 0);
    chk({n, ".nxm"}, bus.busNXM, 0);
    chk({n, ".gnt"}, bus.busGNT, 0);
    chk({n, ".err"}, bus.busERR, 0);
    chk({n, ".intri"}, bus.busINTRI, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc, found, eg[4];
    logic [ND-1:0] seen;
    eg = '{3, 0, 3, 0};
    bus.busREQO = '0;
    bus.busACKO = '0;
    bus.busADDRO = '0;
    bus.busDATAO = '0;
    bus.busINTRO = '0;
    v[0] = '{dev:2, ack:4'b0001, dly:3, addr:36'o100, dat:dat4(0, 36'o123, 0, 36'o777),
             eack:4'b0100, enxm:4'b0000, edat:36'o777, ecyc:5, egnt:2, eerr:1'b0};
    v[1] = '{dev:1, ack:4'b0000, dly:0, addr:36'o200, dat:dat4(0, 0, 36'o11, 0),
             eack:4'b0000, enxm:4'b0010, edat:36'o0, ecyc:TO + 2, egnt:1, eerr:1'b0};
    v[2] = '{dev:1, ack:4'b1001, dly:1, addr:36'o300, dat:dat4(36'o000070, 0, 36'o42, 36'o707000),
             eack:4'b0010, enxm:4'b0000, edat:36'o707070, ecyc:3, egnt:1, eerr:1'b1};
    v[3] = '{dev:0, ack:4'b0001, dly:1, addr:36'o400, dat:dat4(0, 0, 0, 36'o5),
             eack:4'b0000, enxm:4'b0001, edat:36'o0, ecyc:TO + 2, egnt:0, eerr:1'b1};
    v[4] = '{dev:3, ack:4'b0010, dly:TO, addr:36'o500, dat:dat4(36'o1, 0, 36'o555, 0),
             eack:4'b1000, enxm:4'b0000, edat:36'o555, ecyc:TO + 2, egnt:3, eerr:1'b1};
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      bus.busREQO = ND'(1) << v[k].dev;
      bus.busADDRO = '0;
      bus.busADDRO[v[k].dev] = v[k].addr;
      bus.busDATAO = v[k].dat;
      step();
      chk($sformatf("v%0d.reqi", k), bus.busREQI, 1);
      chk($sformatf("v%0d.addri", k), bus.busADDRI, v[k].addr);
      chk($sformatf("v%0d.wdata", k), bus.busDATAI, v[k].dat[v[k].dev]);
      chk($sformatf("v%0d.gnt", k), bus.busGNT, v[k].egnt);
      cyc = -1;
      for (int c = 1; c < 40 && cyc < 0; c++) begin
        bus.busACKO = (c == 1 + v[k].dly) ? v[k].ack : '0;
        step();
        if ((bus.busACKI | bus.busNXM) != '0) cyc = c + 1;
      end
      chk($sformatf("v%0d.done_cycle", k), cyc, v[k].ecyc);
      chk($sformatf("v%0d.acki", k), bus.busACKI, v[k].eack);
      chk($sformatf("v%0d.nxm", k), bus.busNXM, v[k].enxm);
      chk($sformatf("v%0d.rdata", k), bus.busDATAI, v[k].edat);
      chk($sformatf("v%0d.err", k), bus.busERR, v[k].eerr);
      chk($sformatf("v%0d.addr_hold", k), bus.busADDRI, v[k].addr);
      bus.busREQO = '0;
      bus.busACKO = '0;
      step();
      chk($sformatf("v%0d.pulse_end", k), bus.busACKI | bus.busNXM, 0);
    end
    bus.busINTRO[2] = 7'b0000100;
    bus.busINTRO[3] = 7'b1000000;
    chk("intr_latency", bus.busINTRI, 0);
    step();
    chk("intr_merge", bus.busINTRI, 7'b1000100);
    bus.busREQO = 4'b0100;
    bus.busADDRO[2] = 36'o7;
    step();
    chk("abort.gnt", bus.busGNT, 2);
    chk("abort.reqi", bus.busREQI, 1);
    step();
    step();
    rst_n = 1'b0;
    bus.busREQO = '0;
    step();
    chk_zero("midreset");
    rst_n = 1'b1;
    bus.busINTRO = '0;
    seen = '0;
    for (int t = 0; t < 15; t++) begin
      step();
      seen |= bus.busACKI | bus.busNXM;
    end
    chk("abort.no_response", seen, 0);
    bus.busREQO = 4'b1001;
    bus.busACKO = 4'b0010;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int t = 0; t < 12 && found == 0; t++) begin
        step();
        if (bus.busREQI) found = 1;
      end
      chk($sformatf("rr%0d.found", g), found, 1);
      chk($sformatf("rr%0d.gnt", g), bus.busGNT, eg[g]);
    end
    bus.busREQO = '0;
    bus.busACKO = '0;
    step();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
